// File: rtl/decode_in_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_in_queue
// Brief    : Instruction buffer between fetch and decode. A circular FIFO of
//            {npc, instr, psr} entries is filled through a valid/ready push
//            port and drained one entry per cycle into a registered output
//            stage that feeds the decode-stage input bus. The output stage
//            holds under stall, and a flush discards all queued and
//            presented entries.
// Revision : 1.0 - initial release
// ============================================================================
module decode_in_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int PSR_WIDTH  = 3,
    parameter int DEPTH      = 4,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    // fetch side
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_npc,
    input  logic [DATA_WIDTH-1:0] push_instr,
    input  logic [PSR_WIDTH-1:0]  push_psr,
    // decode side
    input  logic                  stall,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] npc_in,
    output logic                  enable_decode,
    output logic [PSR_WIDTH-1:0]  psr,
    output logic [DATA_WIDTH-1:0] instr_dout,
    output logic [CW-1:0]         count
);

    localparam int            c_PTR_W = $clog2(DEPTH);
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    // FIFO storage; contents are only meaningful where count says so, so the
    // array itself carries no reset.
    logic [DATA_WIDTH-1:0] r_mem_npc   [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [PSR_WIDTH-1:0]  r_mem_psr   [DEPTH];

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [CW-1:0]         r_count;

    // registered output stage
    logic [DATA_WIDTH-1:0] r_npc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [PSR_WIDTH-1:0]  r_psr;
    logic                  r_valid;

    logic                  w_push_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;

    // Handshake qualifiers. Readiness depends only on stored occupancy, so a
    // full queue refuses a push even when a pop happens in the same cycle.
    always_comb begin
        w_empty      = (r_count == '0);
        w_push_ready = (r_count < c_DEPTH);
        w_push       = push_valid && w_push_ready && !flush;
        w_pop        = !stall && !flush && !w_empty;
    end

    // Entry write at the write pointer on an accepted push.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_npc[r_wr_ptr]   <= push_npc;
            r_mem_instr[r_wr_ptr] <= push_instr;
            r_mem_psr[r_wr_ptr]   <= push_psr;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: load the head on a pop, drop valid when idle or flushed,
    // hold everything while stalled. Data fields keep their last value when
    // nothing new is loaded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_npc   <= '0;
            r_instr <= '0;
            r_psr   <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            if (w_pop) begin
                r_npc   <= r_mem_npc[r_rd_ptr];
                r_instr <= r_mem_instr[r_rd_ptr];
                r_psr   <= r_mem_psr[r_rd_ptr];
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign push_ready    = w_push_ready;
    assign count         = r_count;
    assign npc_in        = r_npc;
    assign instr_dout    = r_instr;
    assign psr           = r_psr;
    assign enable_decode = r_valid;

endmodule
`default_nettype wire
